onehot_way_sel: RTL

ONEHOT_WAY_SEL -- requirements
Module: onehot_way_sel

---
 rtl/onehot_way_sel_pkg.sv | 17 +
 rtl/bin2onehot.sv | 22 ++
 rtl/onehot_way_sel.sv | 98 +++++++++
 3 files changed

// File: rtl/onehot_way_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_way_sel_pkg
// Brief    : Shared mode encodings and line-count helper for onehot_way_sel.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_way_sel_pkg;

    localparam logic c_mode_direct = 1'b0;
    localparam logic c_mode_rr     = 1'b1;

    function automatic int calc_n(input int width);
        return 1 << width;
    endfunction

endpackage : onehot_way_sel_pkg
`default_nettype wire

// File: rtl/bin2onehot.sv
`default_nettype none
// ============================================================================
// Module   : bin2onehot
// Brief    : Combinational binary index to one-hot line decoder.
// Revision : 1.0 - initial release
// ============================================================================
module bin2onehot
    import onehot_way_sel_pkg::*;
#(
    parameter  int WIDTH = 3,
    localparam int N     = calc_n(WIDTH)
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [N-1:0]     o_onehot
);

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign o_onehot[gi] = (i_bin == WIDTH'(gi));
    end

endmodule : bin2onehot
`default_nettype wire

// File: rtl/onehot_way_sel.sv
`default_nettype none
// ============================================================================
// Module   : onehot_way_sel
// Brief    : Registered one-hot way select, direct decode or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_way_sel
    import onehot_way_sel_pkg::*;
#(
    parameter  int WIDTH = 3,
    localparam int N     = calc_n(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             mode,
    input  logic [WIDTH-1:0] idx_in,
    input  logic [N-1:0]     lock_mask,
    output logic [N-1:0]     y,
    output logic             y_valid,
    output logic             none_free,
    output logic [WIDTH-1:0] ptr
);

    logic [N-1:0]     y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             none_free_q, none_free_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;

    logic             w_found;
    logic [WIDTH-1:0] w_hit_idx;
    logic [WIDTH-1:0] w_cand;
    logic [WIDTH-1:0] w_sel_idx;
    logic [N-1:0]     w_sel_onehot;

    // Rotating priority search: candidate index wraps naturally in WIDTH bits.
    always_comb begin
        w_found   = 1'b0;
        w_hit_idx = ptr_q;
        w_cand    = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = ptr_q + WIDTH'(i);
            if (!w_found && !lock_mask[w_cand]) begin
                w_found   = 1'b1;
                w_hit_idx = w_cand;
            end
        end
    end

    assign w_sel_idx = (mode == c_mode_rr) ? w_hit_idx : idx_in;

    bin2onehot #(
        .WIDTH (WIDTH)
    ) u_bin2onehot (
        .i_bin    (w_sel_idx),
        .o_onehot (w_sel_onehot)
    );

    always_comb begin
        y_d         = y_q;
        ptr_d       = ptr_q;
        y_valid_d   = 1'b0;
        none_free_d = 1'b0;
        if (req) begin
            y_valid_d = 1'b1;
            if (mode == c_mode_direct) begin
                y_d = w_sel_onehot;
            end else if (w_found) begin
                y_d   = w_sel_onehot;
                ptr_d = w_hit_idx + WIDTH'(1);
            end else begin
                y_d         = '0;
                none_free_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            none_free_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            none_free_q <= none_free_d;
            ptr_q       <= ptr_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign none_free = none_free_q;
    assign ptr       = ptr_q;

endmodule : onehot_way_sel
`default_nettype wire
